// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle: pipeline result port, multi-cycle result port,
// register-file write port and pending scoreboard.
interface wb_arbiter_if #(
    parameter int unsigned DSIZE = 16,
    parameter int unsigned RSIZE = 4,
    parameter int unsigned NREG  = 16
);
    logic             p_valid;
    logic             p_wen;
    logic [RSIZE-1:0] p_waddr;
    logic [DSIZE-1:0] p_wdata;
    logic             p_stall;

    logic             m_issue;
    logic [RSIZE-1:0] m_issue_addr;
    logic             m_valid;
    logic             m_ready;
    logic [RSIZE-1:0] m_waddr;
    logic [DSIZE-1:0] m_wdata;

    logic             wen;
    logic [RSIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic [NREG-1:0]  pending;

    // Arbiter side
    modport slave (
        input  p_valid, p_wen, p_waddr, p_wdata,
        input  m_issue, m_issue_addr, m_valid, m_waddr, m_wdata,
        output p_stall, m_ready, wen, waddr, wdata, pending
    );

    // Producer / register-file side
    modport master (
        output p_valid, p_wen, p_waddr, p_wdata,
        output m_issue, m_issue_addr, m_valid, m_waddr, m_wdata,
        input  p_stall, m_ready, wen, waddr, wdata, pending
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline and multi-cycle results onto the single
// register-file write port, with a small result FIFO and pending scoreboard.
module wb_arbiter #(
    parameter int unsigned DSIZE      = 16,
    parameter int unsigned RSIZE      = 4,
    parameter int unsigned NREG       = 16,
    parameter int unsigned QDEPTH     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    typedef struct packed {
        logic [RSIZE-1:0] addr;
        logic [DSIZE-1:0] data;
    } entry_t;

    entry_t           mem_q [QDEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [SW-1:0]    starve_q;
    logic             p_stall_q;
    logic             wen_q;
    logic [RSIZE-1:0] waddr_q;
    logic [DSIZE-1:0] wdata_q;
    logic [NREG-1:0]  pending_q;

    logic             pipe_write_c;
    logic             fifo_empty_c;
    logic             m_ready_c;
    logic             push_c;
    logic             pop_c;
    entry_t           head_c;
    logic             head_live_c;
    logic [CW-1:0]    count_nxt;
    logic [SW-1:0]    starve_nxt;
    logic             p_stall_nxt;
    logic [NREG-1:0]  pending_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Slot arbitration, FIFO bookkeeping, starvation and scoreboard next-state
    always_comb begin
        pipe_write_c = !p_stall_q && bus.p_valid && bus.p_wen && (bus.p_waddr != '0);
        fifo_empty_c = (count_q == '0);
        m_ready_c    = (count_q < CW'(QDEPTH));
        push_c       = bus.m_valid && m_ready_c;
        pop_c        = !pipe_write_c && !fifo_empty_c;
        head_c       = mem_q[rd_ptr_q];
        head_live_c  = (head_c.addr != '0);

        count_nxt = count_q;
        if (push_c && !pop_c) begin
            count_nxt = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count_q - CW'(1);
        end

        // Head age: counts edges the head waited behind pipeline writes
        starve_nxt  = '0;
        p_stall_nxt = 1'b0;
        if (!fifo_empty_c && !pop_c) begin
            starve_nxt  = starve_q + SW'(1);
            p_stall_nxt = (starve_nxt == SW'(STARVE_MAX - 1));
        end

        // A new issue to the same register outranks the retiring write
        pending_nxt = pending_q;
        if (pop_c && head_live_c) begin
            pending_nxt[head_c.addr] = 1'b0;
        end
        if (bus.m_issue && (bus.m_issue_addr != '0)) begin
            pending_nxt[bus.m_issue_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            p_stall_q <= 1'b0;
            pending_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q   <= count_nxt;
            starve_q  <= starve_nxt;
            p_stall_q <= p_stall_nxt;
            pending_q <= pending_nxt;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= '{addr: bus.m_waddr, data: bus.m_wdata};
        end
    end

    // Register-file write port; address/data hold when no write is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (pipe_write_c) begin
            wen_q   <= 1'b1;
            waddr_q <= bus.p_waddr;
            wdata_q <= bus.p_wdata;
        end else if (pop_c && head_live_c) begin
            wen_q   <= 1'b1;
            waddr_q <= head_c.addr;
            wdata_q <= head_c.data;
        end else begin
            wen_q   <= 1'b0;
        end
    end

    assign bus.p_stall = p_stall_q;
    assign bus.m_ready = m_ready_c;
    assign bus.wen     = wen_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;
    localparam int unsigned DSIZE      = 16;
    localparam int unsigned RSIZE      = 4;
    localparam int unsigned NREG       = 16;
    localparam int unsigned QDEPTH     = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DSIZE(DSIZE), .RSIZE(RSIZE), .NREG(NREG)) bus ();

    wb_arbiter #(
        .DSIZE(DSIZE), .RSIZE(RSIZE), .NREG(NREG),
        .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int addr;
        int data;
    } ent_t;

    // Reference model state
    ent_t            q[$];
    int              age;
    bit              mstall;
    bit              mwen;
    int              mwaddr;
    int              mwdata;
    logic [NREG-1:0] mpend;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("wen",     32'(bus.wen),     32'(mwen));
        check("waddr",   32'(bus.waddr),   32'(mwaddr));
        check("wdata",   32'(bus.wdata),   32'(mwdata));
        check("p_stall", 32'(bus.p_stall), 32'(mstall));
        check("m_ready", 32'(bus.m_ready), 32'(q.size() < QDEPTH));
        check("pending", 32'(bus.pending), 32'(mpend));
    endtask

    task automatic model_reset();
        q.delete();
        age    = 0;
        mstall = 0;
        mwen   = 0;
        mwaddr = 0;
        mwdata = 0;
        mpend  = '0;
    endtask

    // One rising edge of the reference behaviour, using the stimulus now on the bus
    task automatic model_edge();
        bit   pw, pop, was_nonempty, can_push;
        ent_t h;
        pw           = !mstall && bus.p_valid && bus.p_wen && (bus.p_waddr != 0);
        was_nonempty = (q.size() > 0);
        can_push     = (q.size() < QDEPTH);
        pop          = !pw && was_nonempty;
        mwen = 0;
        if (pw) begin
            mwen   = 1;
            mwaddr = int'(bus.p_waddr);
            mwdata = int'(bus.p_wdata);
        end else if (pop) begin
            h = q.pop_front();
            if (h.addr != 0) begin
                mwen      = 1;
                mwaddr    = h.addr;
                mwdata    = h.data;
                mpend[h.addr] = 1'b0;
            end
        end
        if (bus.m_issue && bus.m_issue_addr != 0) mpend[bus.m_issue_addr] = 1'b1;
        if (bus.m_valid && can_push) q.push_back('{int'(bus.m_waddr), int'(bus.m_wdata)});
        if (was_nonempty && !pop) age++;
        else age = 0;
        mstall = (age == STARVE_MAX - 1);
    endtask

    task automatic drive(input bit pv, input bit pwe, input int pa, input int pd,
                         input bit mi, input int mia, input bit mv, input int ma, input int md);
        bus.p_valid      = pv;
        bus.p_wen        = pwe;
        bus.p_waddr      = RSIZE'(pa);
        bus.p_wdata      = DSIZE'(pd);
        bus.m_issue      = mi;
        bus.m_issue_addr = RSIZE'(mia);
        bus.m_valid      = mv;
        bus.m_waddr      = RSIZE'(ma);
        bus.m_wdata      = DSIZE'(md);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic random_phase(input int cycles, input int p_pct, input int m_pct, input int i_pct);
        int pa, pd;
        bit pv, pwe;
        pv = 0; pwe = 0; pa = 0; pd = 0;
        for (int c = 0; c < cycles; c++) begin
            // Upstream holds its result while stalled
            if (!mstall) begin
                pv  = ($urandom_range(0, 99) < p_pct);
                pwe = ($urandom_range(0, 9) != 0);
                pa  = int'($urandom_range(0, NREG - 1));
                pd  = int'($urandom_range(0, 16'hFFFF));
            end
            drive(pv, pwe, pa, pd,
                  ($urandom_range(0, 99) < i_pct), int'($urandom_range(0, NREG - 1)),
                  ($urandom_range(0, 99) < m_pct), int'($urandom_range(0, NREG - 1)),
                  int'($urandom_range(0, 16'hFFFF)));
            step();
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_m_ready", 32'(bus.m_ready), 32'h1);

        // Pipeline write R3
        drive(1, 1, 3, 16'h1234, 0, 0, 0, 0, 0);
        step();
        check("p_wen", 32'(bus.wen), 32'h1);
        check("p_waddr", 32'(bus.waddr), 32'h3);
        check("p_wdata", 32'(bus.wdata), 32'h1234);
        idle_step();

        // Multi-cycle R5: issue, handshake, pop
        drive(0, 0, 0, 0, 1, 5, 0, 0, 0);
        step();
        check("pend5_set", 32'(bus.pending[5]), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 1, 5, 16'hBEEF);
        step();
        check("m_no_early", 32'(bus.wen), 32'h0);
        idle_step();
        check("m_wen", 32'(bus.wen), 32'h1);
        check("m_waddr", 32'(bus.waddr), 32'h5);
        check("m_wdata", 32'(bus.wdata), 32'hBEEF);
        check("pend5_clr", 32'(bus.pending[5]), 32'h0);

        // Starvation: pipeline busy every cycle, two multi-cycle results queued
        for (int c = 0; c < 14; c++) begin
            if (c == 0)      drive(1, 1, 1 + (c % 15), c, 0, 0, 1, 6, 16'h0006);
            else if (c == 1) drive(1, 1, 1 + (c % 15), c, 0, 0, 1, 7, 16'h0007);
            else             drive(1, 1, 1 + (c % 15), c, 0, 0, 0, 0, 0);
            step();
        end
        repeat (3) idle_step();

        // Issue R4 while an R4 entry retires at the same edge
        drive(0, 0, 0, 0, 0, 0, 1, 4, 16'h0444);
        step();
        drive(0, 0, 0, 0, 1, 4, 0, 0, 0);
        step();
        check("pend4_keep", 32'(bus.pending[4]), 32'h1);
        check("pend4_wr", 32'(bus.waddr), 32'h4);

        // Pipeline write to R0 lets the FIFO pop
        drive(0, 0, 0, 0, 0, 0, 1, 8, 16'h0888);
        step();
        drive(1, 1, 0, 16'hDEAD, 0, 0, 0, 0, 0);
        step();
        check("r0_pop_waddr", 32'(bus.waddr), 32'h8);
        idle_step();

        // Reset with queued entries and Pending[9]
        drive(0, 0, 0, 0, 1, 9, 0, 0, 0);
        step();
        drive(1, 1, 2, 16'h2222, 0, 0, 1, 9, 16'h0999);
        step();
        drive(1, 1, 3, 16'h3333, 0, 0, 1, 2, 16'h0222);
        step();
        check("pre_rst_pend9", 32'(bus.pending[9]), 32'h1);
        check("pre_rst_full", 32'(bus.m_ready), 32'h0);
        async_reset();
        check("post_rst_pend", 32'(bus.pending), 32'h0);
        check("post_rst_wen", 32'(bus.wen), 32'h0);
        repeat (4) idle_step();
        check("no_stale", 32'(bus.wen), 32'h0);

        // Randomized traffic at several densities
        random_phase(600, 50, 40, 30);
        random_phase(600, 95, 70, 50);
        async_reset();
        random_phase(600, 20, 90, 60);
        random_phase(600, 80, 20, 20);
        async_reset();
        random_phase(400, 100, 100, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
